// File: rtl/life_pkg.sv
// Shared op codes, FSM states and neighbour-sum width for the Game-of-Life grid engine.
package life_pkg;
  localparam int NBR_W = 4;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_RUN   = 2'd1,
    OP_READ  = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    COMMIT,
    READ,
    DONE
  } state_t;
endpackage

// File: rtl/life_nbr_count.sv
// Combinational live-neighbour count for cell (r, c) of a toroidal ROWS x COLS grid.
// Zero latency; no flow control.
module life_nbr_count
  import life_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
) (
  input  logic [ROWS*COLS-1:0] grid,
  input  logic [RW-1:0]        r,
  input  logic [CW-1:0]        c,
  output logic [NBR_W-1:0]     sum
);
  localparam int IW = $clog2(ROWS*COLS);

  logic [RW-1:0] row_sel [3];
  logic [CW-1:0] col_sel [3];
  logic [IW-1:0] ni;

  always_comb begin
    row_sel[0] = (r == RW'(0)) ? RW'(ROWS-1) : r - RW'(1);
    row_sel[1] = r;
    row_sel[2] = (r == RW'(ROWS-1)) ? RW'(0) : r + RW'(1);
    col_sel[0] = (c == CW'(0)) ? CW'(COLS-1) : c - CW'(1);
    col_sel[1] = c;
    col_sel[2] = (c == CW'(COLS-1)) ? CW'(0) : c + CW'(1);
    sum = '0;
    ni  = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        if (!(dr == 1 && dc == 1)) begin
          ni  = IW'(row_sel[dr]) * IW'(COLS) + IW'(col_sel[dc]);
          sum = sum + NBR_W'(grid[ni]);
        end
      end
    end
  end
endmodule

// File: rtl/life_grid_engine.sv
// Toroidal Game-of-Life engine: RUN of g generations takes g*(N+1) cycles plus one DONE cycle; load/read stall on in_valid/out_ready.
// Optional LIFE_STABLE_DETECT_EN: builds the still-life comparator and ends a RUN early on still-life or extinction.
module life_grid_engine
  import life_pkg::*;
#(
  parameter int         ROWS         = 4,
  parameter int         COLS         = 4,
  parameter int         GEN_W        = 8,
  parameter logic [8:0] BIRTH_MASK   = 9'b000001000,
  parameter logic [8:0] SURVIVE_MASK = 9'b000001100
) (
  input  logic             clka,
  input  logic             restart_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [GEN_W-1:0] cmd_gens,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             extinct,
  output logic             stable,
  output logic [GEN_W-1:0] gen_count
);
  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  state_t           state;
  logic [N-1:0]     cur, nxt;
  logic [IW-1:0]    idx, idx_nx;
  logic [RW-1:0]    row, row_nx;
  logic [CW-1:0]    col, col_nx;
  logic [GEN_W-1:0] gens_left;
  logic [NBR_W-1:0] sum;
  logic             last_cell, next_bit;

  life_nbr_count #(.ROWS(ROWS), .COLS(COLS), .RW(RW), .CW(CW)) u_nbr (
    .grid (cur),
    .r    (row),
    .c    (col),
    .sum  (sum)
  );

  // Row/column counters walk alongside idx so no divide/modulo is needed.
  always_comb begin
    last_cell = (idx == IW'(N-1));
    idx_nx    = last_cell ? '0 : idx + IW'(1);
    col_nx    = (col == CW'(COLS-1)) ? '0 : col + CW'(1);
    row_nx    = row;
    if (col == CW'(COLS-1))
      row_nx = (row == RW'(ROWS-1)) ? '0 : row + RW'(1);
    next_bit  = cur[idx] ? SURVIVE_MASK[sum] : BIRTH_MASK[sum];
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign in_ready  = (state == LOAD);
  assign out_valid = (state == READ);
  assign out_bit   = (state == READ) ? cur[idx] : 1'b0;
  assign out_last  = (state == READ) && last_cell;

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state     <= IDLE;
      cur       <= '0;
      nxt       <= '0;
      idx       <= '0;
      row       <= '0;
      col       <= '0;
      gens_left <= '0;
      gen_count <= '0;
      extinct   <= 1'b0;
      done      <= 1'b0;
`ifdef LIFE_STABLE_DETECT_EN
      stable    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          case (op_t'(cmd_op))
            OP_LOAD: state <= LOAD;
            OP_RUN: begin
              gens_left <= cmd_gens;
              if (cmd_gens == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= COMPUTE;
              end
            end
            OP_READ: state <= READ;
            OP_CLEAR: begin
              cur       <= '0;
              gen_count <= '0;
              extinct   <= 1'b1;
`ifdef LIFE_STABLE_DETECT_EN
              stable    <= 1'b0;
`endif
            end
            default: state <= IDLE;
          endcase
        end
        LOAD: if (in_valid) begin
          cur[idx] <= in_bit;
          idx <= idx_nx;
          row <= row_nx;
          col <= col_nx;
          if (last_cell) begin
            gen_count <= '0;
            extinct   <= 1'b0;
`ifdef LIFE_STABLE_DETECT_EN
            stable    <= 1'b0;
`endif
            state     <= IDLE;
          end
        end
        COMPUTE: begin
          nxt[idx] <= next_bit;
          idx <= idx_nx;
          row <= row_nx;
          col <= col_nx;
          if (last_cell) state <= COMMIT;
        end
        COMMIT: begin
          cur       <= nxt;
          extinct   <= (nxt == '0);
          gen_count <= (gen_count == '1) ? gen_count : gen_count + GEN_W'(1);
          gens_left <= gens_left - GEN_W'(1);
`ifdef LIFE_STABLE_DETECT_EN
          stable    <= (nxt == cur);
          if (gens_left == GEN_W'(1) || nxt == '0 || nxt == cur) begin
`else
          if (gens_left == GEN_W'(1)) begin
`endif
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= COMPUTE;
          end
        end
        READ: if (out_ready) begin
          idx <= idx_nx;
          row <= row_nx;
          col <= col_nx;
          if (last_cell) state <= IDLE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifndef LIFE_STABLE_DETECT_EN
  assign stable = 1'b0;
`endif
endmodule
